// File: rtl/bcd_xs3_stream_conv_if.sv
// Stream bundle for the BCD <-> Excess-3 word converter: one input word
// channel (with its conversion mode) and one result channel.
interface bcd_xs3_stream_conv_if #(
    parameter int DIGITS = 4
);
    logic                  mode;
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_data;
    logic [DIGITS-1:0]     out_err_mask;
    logic                  out_mode;

    // Producer/consumer side (drives words in, takes results out)
    modport master (
        output mode, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err_mask, out_mode
    );

    // Converter side
    modport slave (
        input  mode, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err_mask, out_mode
    );
endinterface

// File: rtl/bcd_xs3_stream_conv.sv
// Digit-serial BCD <-> Excess-3 word converter.
// A word is captured in IDLE, converted one digit per cycle in CONV, and
// presented in DONE until the consumer takes it. Invalid digit codes become
// 4'h0 and are flagged in a per-digit mask; words carrying any invalid digit
// are counted by a saturating counter.
// Timing: counting the accepting edge as the first, out_valid is seen after
// the (DIGITS+1)th rising edge; a word occupies DIGITS+2 cycles end to end.
module bcd_xs3_stream_conv #(
    parameter int DIGITS = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    bcd_xs3_stream_conv_if.slave bus,
    output logic [CNT_W-1:0]  err_count
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int W     = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t             state_reg,     state_next;
    logic [IDX_W-1:0]   idx_reg,       idx_next;
    logic [W-1:0]       data_reg,      data_next;
    logic               mode_reg,      mode_next;
    logic [W-1:0]       work_data_reg, work_data_next;
    logic [DIGITS-1:0]  work_mask_reg, work_mask_next;
    logic [W-1:0]       out_data_reg,  out_data_next;
    logic [DIGITS-1:0]  out_mask_reg,  out_mask_next;
    logic               out_mode_reg,  out_mode_next;
    logic [CNT_W-1:0]   err_cnt_reg,   err_cnt_next;

    // Per-digit conversion of the captured word; CONV picks one per cycle
    logic [3:0]         conv_digit [DIGITS];
    logic [DIGITS-1:0]  conv_bad;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] code;
            assign code = data_reg[4*gi +: 4];

            // Decode one digit in the captured mode; invalid codes yield 0
            always_comb begin
                conv_bad[gi]   = 1'b0;
                conv_digit[gi] = 4'h0;
                if (!mode_reg) begin
                    if (code > 4'd9) conv_bad[gi]   = 1'b1;
                    else             conv_digit[gi] = code + 4'd3;
                end else begin
                    if (code < 4'd3 || code > 4'd12) conv_bad[gi]   = 1'b1;
                    else                             conv_digit[gi] = code - 4'd3;
                end
            end
        end
    endgenerate

    // Next-state and datapath update for the IDLE/CONV/DONE sequence
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        data_next      = data_reg;
        mode_next      = mode_reg;
        work_data_next = work_data_reg;
        work_mask_next = work_mask_reg;
        out_data_next  = out_data_reg;
        out_mask_next  = out_mask_reg;
        out_mode_next  = out_mode_reg;
        err_cnt_next   = err_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    data_next      = bus.in_data;
                    mode_next      = bus.mode;
                    idx_next       = '0;
                    work_data_next = '0;
                    work_mask_next = '0;
                    state_next     = CONV;
                end
            end
            CONV: begin
                work_data_next[{idx_reg, 2'b00} +: 4] = conv_digit[idx_reg];
                work_mask_next[idx_reg]               = conv_bad[idx_reg];
                if (idx_reg == IDX_W'(DIGITS - 1)) begin
                    // Publish the finished word in the same cycle as its last digit
                    out_data_next = work_data_next;
                    out_mask_next = work_mask_next;
                    out_mode_next = mode_reg;
                    state_next    = DONE;
                end else begin
                    idx_next = idx_reg + IDX_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                    if ((|out_mask_reg) && (err_cnt_reg != {CNT_W{1'b1}}))
                        err_cnt_next = err_cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset discards any word in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            data_reg      <= '0;
            mode_reg      <= 1'b0;
            work_data_reg <= '0;
            work_mask_reg <= '0;
            out_data_reg  <= '0;
            out_mask_reg  <= '0;
            out_mode_reg  <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            data_reg      <= data_next;
            mode_reg      <= mode_next;
            work_data_reg <= work_data_next;
            work_mask_reg <= work_mask_next;
            out_data_reg  <= out_data_next;
            out_mask_reg  <= out_mask_next;
            out_mode_reg  <= out_mode_next;
            err_cnt_reg   <= err_cnt_next;
        end
    end

    // in_ready is masked by rst so nothing looks acceptable during reset
    assign bus.in_ready     = (state_reg == IDLE) && !rst;
    assign bus.out_valid    = (state_reg == DONE);
    assign bus.out_data     = out_data_reg;
    assign bus.out_err_mask = out_mask_reg;
    assign bus.out_mode     = out_mode_reg;
    assign err_count        = err_cnt_reg;
endmodule

// File: doc/bcd_xs3_stream_conv.md
BCD_XS3_STREAM_CONV -- requirements
Module: bcd_xs3_stream_conv

Interface
REQ-001 Parameter: DIGITS, default 4, number of 4-bit digits per word (range 1-16).
REQ-002 Parameter: CNT_W, default 8, width of the error-word counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 mode  input  1  0 = BCD to Excess-3, 1 = Excess-3 to BCD; sampled only on input handshake.
REQ-006 in_valid  input  1  input word present.
REQ-007 in_ready  output  1  block can accept a word.
REQ-008 in_data  input  4*DIGITS  packed digits; digit k = in_data[4k+3:4k], k=0 least significant.
REQ-009 out_valid  output  1  result word present.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_data  output  4*DIGITS  converted digits, same packing as in_data.
REQ-012 out_err_mask  output  DIGITS  bit k set = digit k was an invalid code.
REQ-013 out_mode  output  1  mode the current result was converted with.
REQ-014 err_count  output  CNT_W  count of completed words with any invalid digit; saturates at all-ones.

Function
REQ-015 The FSM SHALL have states IDLE, CONV, DONE.
REQ-016 IDLE: in_ready=1; on in_valid=1, capture in_data and mode, clear the digit index to 0, clear the working mask, go to CONV.
REQ-017 CONV: per cycle convert digit[index] into the working result, set its mask bit if invalid, increment index; after digit DIGITS-1 go to DONE.
REQ-018 DONE: out_valid=1, and out_data, out_err_mask and out_mode SHALL be held stable; on out_ready=1 go to IDLE.
REQ-019 in_ready SHALL be 0 in CONV and DONE; in_valid outside IDLE is ignored.
REQ-020 Latency: out_valid SHALL rise exactly DIGITS+1 rising edges after the accepting edge.
REQ-021 Throughput: one word per DIGITS+2 cycles with out_ready held high.
REQ-022 BCD to XS3: code 0-9 gives code+3, modulo 4 bits; codes 10-15 are invalid.
REQ-023 XS3 to BCD: code 3-12 gives code-3; codes 0-2 and 13-15 are invalid.
REQ-024 An invalid digit SHALL produce output code 4'h0 and set its mask bit; the other digits convert normally.
REQ-025 err_count SHALL increment by 1 on the DONE-to-IDLE transition when out_err_mask is nonzero; it holds at 2^CNT_W-1.
REQ-026 out_data, out_err_mask and out_mode SHALL hold their last result in IDLE and CONV; only out_valid qualifies them.
REQ-027 A change on mode or in_data after capture SHALL have no effect on the word in flight.

Reset
REQ-028 While rst=1 at a rising edge: state becomes IDLE, index 0, out_valid 0, out_data 0, out_err_mask 0, out_mode 0, err_count 0.
REQ-029 in_ready SHALL be 0 while rst is high and 1 in the first cycle after rst deasserts.
REQ-030 Reset in CONV or DONE SHALL discard the word in flight; no out_valid is produced for it and err_count is not updated.
REQ-031 rst has priority over all handshakes in the same cycle.

Verification (DIGITS=4)
REQ-032 mode=0, in_data=16'h1234 -> out_data=16'h4567, mask=4'b0000, out_valid 5 edges after accept.
REQ-033 mode=1, in_data=16'h4567 -> out_data=16'h1234, mask=4'b0000, out_mode=1.
REQ-034 mode=0, in_data=16'h9A05 -> out_data=16'hC038, mask=4'b0100, err_count 0->1 after out handshake.
REQ-035 mode=1, in_data=16'h3C02 -> out_data=16'h0900, mask=4'b0011; repeat 300 times with CNT_W=8 -> err_count saturates at 255.
REQ-036 out_ready held 0 for 5 cycles in DONE, in_valid=1 with a new word -> outputs stable, in_ready=0, new word not taken; accepted after the out handshake and return to IDLE.
REQ-037 rst pulsed during CONV (index=2) -> next edge out_valid=0, err_count=0, in_ready=1 the cycle after rst falls, no stale result emitted.
